point_sub: RTL and testbench
============================

Name: point_sub

Overview:
- Computes R = P − Q on the short-Weierstrass curve y² = x³ + 7 over GF(p), affine coordinates, one subtraction per Start.
- Q is negated internally (−Q = (Qx, p − Qy)), then a chord addition runs.
- The chord addition is sequenced through one shared modular multiplier and one modular_inverse under an explicit FSM, with Start/Busy/Done handshake and point-at-infinity handling.
- Sits beside the point-addition block in the scalar-multiplication datapath and serves signed-window / NAF ladders.

Parameters:
- P_MOD, 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F: field prime (secp256k1).
- W, 256: coordinate width.

Ports:
- clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  request. Sampled only in IDLE or DONE.
- Px, Py, Qx, Qy  in  W  operands, fully reduced (< P_MOD). Captured on the accepted Start.
- P_inf, Q_inf  in  1  operand is the point at infinity. Coordinates are ignored when set.
- Busy  out  1  high from the cycle after an accepted Start until Done rises.
- Done  out  1  result valid. Held until the next accepted Start.
- Err  out  1  valid with Done. Set when P = −Q, i.e. a doubling case, which this block does not support.
- R_inf  out  1  result is the point at infinity. Valid with Done.
- Rx, Ry  out  W  result. Valid with Done; held stable while Done is high.

Behaviour:
- Reset low (async):
  - FSM → IDLE.
  - Busy, Done, Err, R_inf = 0.
  - Rx, Ry = 0.
  - All operand and intermediate registers cleared.
  - Submodule start strobes deasserted.
- Reset mid-operation aborts immediately. No partial result is ever flagged Done.
- Accepted Start (in IDLE or DONE):
  - Latch the operands.
  - Clear Done, Err, R_inf.
  - Go to CHK.
  - Start is ignored in all other states.
- CHK, 1 cycle, priority order:
  - P_inf & Q_inf → result infinity.
  - P_inf → R = (Qx, nQy), where nQy = (Qy == 0) ? 0 : P_MOD − Qy.
  - Q_inf → R = (Px, Py).
  - Px == Qx & Py == Qy → infinity.
  - Px == Qx otherwise → Err = 1, R_inf = 1, Rx = Ry = 0.
  - Any of the above → DONE. Else → NUM.
- NUM, 1 cycle:
  - num = Py − nQy mod p (equivalently Py + Qy mod p).
  - den = Px − Qx mod p.
  - Subtraction rule: a − b mod p = (a ≥ b) ? a − b : a − b + P_MOD, computed in W+1 bits.
- INV: assert inverse start; wait for its Done; latch inv = den⁻¹.
- MUL_S: shared multiplier, s = num·inv mod p.
- MUL_S2: s2 = s·s mod p.
- XR, 1 cycle: Rx_t = s2 − Px − Qx mod p (two chained modular subtractions); d = Px − Rx_t mod p.
- MUL_Y: t = s·d mod p.
- YR, 1 cycle: Ry_t = t − Py mod p. Load Rx, Ry. Go to DONE.
- Multiplier handling:
  - Exactly one multiplier instance.
  - Operand muxes are selected by state.
  - The multiplier is held in its reset while not in a MUL_* state.
  - A result is latched only on the first cycle its Done is seen in that state.
- DONE: Done = 1, Busy = 0. Outputs hold until the next accepted Start.
- Latency:
  - Special cases: Done 2 cycles after the Start edge.
  - General case: Done is data-dependent: 5 + T_inv + 3·T_mul + 3 state-entry cycles. The bench reads Done, never a fixed count.
- Start high continuously while DONE begins a new operation on the next cycle. Done drops that cycle.
- Start and Reset low in the same cycle: Reset wins.

Test Plan:
- Operands:
  - G = (79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798, 483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8).
  - 2G = (C6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5, 1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A).
- P = 2G, Q = G, Start 1 cycle → Done with R = G, Err = 0, R_inf = 0; Busy high throughout.
- P = G, Q = 2G → Rx = Gx, Ry = P_MOD − Gy = B7C52588D95C3B9AA25B0403F1EEF75702E84BB7597AABE663B82F6F04EF2777.
- P = Q = G → Done 2 cycles after Start, R_inf = 1, Err = 0. Then P = G, Q = (Gx, P_MOD − Gy) → Err = 1, R_inf = 1.
- Infinity operands:
  - P_inf = 1, Q = G → R = −G.
  - Q_inf = 1, P = 2G → R = 2G.
  - Both set → R_inf = 1.
- Reset pulled low during MUL_S2 of the first case → all outputs 0 immediately. A re-run after release yields R = G.
- Back-to-back: Start held high across two operations → second result correct; Done drops for ≥1 cycle between results.

Source files
------------

// File: rtl/point_sub.sv
// point_sub: affine R = P - Q on y^2 = x^3 + 7 over GF(P_MOD).
// -Q = (Qx, p - Qy), then a chord addition sequenced through one shared
// modular multiplier and one modular inverse.

// Bit-serial interleaved modular multiplier; clr holds it idle and captures operands.
module pt_mod_mul #(
  parameter int unsigned W     = 256,
  parameter logic [W-1:0] P_MOD = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] p
);
  localparam int unsigned CW = $clog2(W) + 1;

  logic [W-1:0]  acc_q, acc_d, a_q, a_d, b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic [W:0]    dbl, sum;

  // One MSB-first double-and-add step per cycle, both partials kept below P_MOD.
  always_comb begin
    acc_d  = acc_q;
    a_d    = a_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    dbl    = '0;
    sum    = '0;
    if (clr) begin
      acc_d  = '0;
      a_d    = a;
      b_d    = b;
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (!done_q) begin
      dbl = {acc_q, 1'b0};
      if (dbl >= {1'b0, P_MOD}) dbl = dbl - {1'b0, P_MOD};
      sum = dbl + (b_q[W-1] ? {1'b0, a_q} : '0);
      if (sum >= {1'b0, P_MOD}) sum = sum - {1'b0, P_MOD};
      acc_d = W'(sum);
      b_d   = b_q << 1;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(W - 1)) done_d = 1'b1;
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      a_q    <= a_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign p    = acc_q;
endmodule

// Binary extended-Euclid inverse; a must be nonzero. done holds until next start.
module modular_inverse #(
  parameter int unsigned W     = 256,
  parameter logic [W-1:0] P_MOD = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  output logic         done,
  output logic [W-1:0] r
);
  logic [W-1:0] u_q, u_d, v_q, v_d, x1_q, x1_d, x2_q, x2_d, r_q, r_d;
  logic         busy_q, busy_d, done_q, done_d;

  function automatic logic [W-1:0] sub_mod(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] t;
    t = {1'b0, x} - {1'b0, y};
    if (x < y) t = t + {1'b0, P_MOD};
    return W'(t);
  endfunction

  function automatic logic [W-1:0] half_mod(input logic [W-1:0] x);
    logic [W:0] t;
    t = x[0] ? ({1'b0, x} + {1'b0, P_MOD}) : {1'b0, x};
    return W'(t >> 1);
  endfunction

  // Invariants a*x1 = u and a*x2 = v (mod p); stop when either reaches 1.
  always_comb begin
    u_d = u_q; v_d = v_q; x1_d = x1_q; x2_d = x2_q; r_d = r_q;
    busy_d = busy_q;
    done_d = done_q;
    if (start) begin
      u_d = a; v_d = P_MOD; x1_d = W'(1); x2_d = '0;
      busy_d = 1'b1;
      done_d = 1'b0;
    end else if (busy_q) begin
      if (u_q == W'(1)) begin
        r_d = x1_q; busy_d = 1'b0; done_d = 1'b1;
      end else if (v_q == W'(1)) begin
        r_d = x2_q; busy_d = 1'b0; done_d = 1'b1;
      end else if (!u_q[0]) begin
        u_d = u_q >> 1; x1_d = half_mod(x1_q);
      end else if (!v_q[0]) begin
        v_d = v_q >> 1; x2_d = half_mod(x2_q);
      end else if (u_q >= v_q) begin
        u_d = u_q - v_q; x1_d = sub_mod(x1_q, x2_q);
      end else begin
        v_d = v_q - u_q; x2_d = sub_mod(x2_q, x1_q);
      end
    end
  end

  // Inverse state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_q <= '0; v_q <= '0; x1_q <= '0; x2_q <= '0; r_q <= '0;
      busy_q <= 1'b0; done_q <= 1'b0;
    end else begin
      u_q <= u_d; v_q <= v_d; x1_q <= x1_d; x2_q <= x2_d; r_q <= r_d;
      busy_q <= busy_d; done_q <= done_d;
    end
  end

  assign done = done_q;
  assign r    = r_q;
endmodule

// Point subtraction sequencer.
module point_sub #(
  parameter int unsigned W     = 256,
  parameter logic [W-1:0] P_MOD = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [W-1:0] Px,
  input  logic [W-1:0] Py,
  input  logic [W-1:0] Qx,
  input  logic [W-1:0] Qy,
  input  logic         P_inf,
  input  logic         Q_inf,
  output logic         Busy,
  output logic         Done,
  output logic         Err,
  output logic         R_inf,
  output logic [W-1:0] Rx,
  output logic [W-1:0] Ry
);
  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_CHK = 4'd1, S_NUM = 4'd2, S_INV = 4'd3, S_MUL_S = 4'd4,
    S_MUL_S2 = 4'd5, S_XR = 4'd6, S_MUL_Y = 4'd7, S_YR = 4'd8, S_DONE = 4'd9
  } state_t;

  state_t       state_q, state_d;
  logic         ent_q, ent_d;
  logic [W-1:0] px_q, px_d, py_q, py_d, qx_q, qx_d, qy_q, qy_d;
  logic         pinf_q, pinf_d, qinf_q, qinf_d;
  logic [W-1:0] num_q, num_d, den_q, den_d, inv_q, inv_d, s_q, s_d, s2_q, s2_d;
  logic [W-1:0] rxt_q, rxt_d, dd_q, dd_d, t_q, t_d, rx_q, rx_d, ry_q, ry_d;
  logic         busy_q, busy_d, done_q, done_d, err_q, err_d, rinf_q, rinf_d;
  logic [W-1:0] nqy_c, mul_a_c, mul_b_c, mul_p, inv_r;
  logic         mul_clr_c, mul_done, inv_start_c, inv_done;

  function automatic logic [W-1:0] sub_mod(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] t;
    t = {1'b0, x} - {1'b0, y};
    if (x < y) t = t + {1'b0, P_MOD};
    return W'(t);
  endfunction

  assign nqy_c = (qy_q == '0) ? '0 : P_MOD - qy_q;

  pt_mod_mul #(.W(W), .P_MOD(P_MOD)) u_mul (
    .clk(clk), .rst_n(Reset), .clr(mul_clr_c), .a(mul_a_c), .b(mul_b_c),
    .done(mul_done), .p(mul_p));

  modular_inverse #(.W(W), .P_MOD(P_MOD)) u_inv (
    .clk(clk), .rst_n(Reset), .start(inv_start_c), .a(den_q),
    .done(inv_done), .r(inv_r));

  // Next state, datapath updates and submodule control; entry cycle of each
  // MUL_*/INV state (ent_q) restarts the shared unit so stale Done is never taken.
  always_comb begin
    state_d = state_q;
    px_d = px_q; py_d = py_q; qx_d = qx_q; qy_d = qy_q;
    pinf_d = pinf_q; qinf_d = qinf_q;
    num_d = num_q; den_d = den_q; inv_d = inv_q; s_d = s_q; s2_d = s2_q;
    rxt_d = rxt_q; dd_d = dd_q; t_d = t_q; rx_d = rx_q; ry_d = ry_q;
    busy_d = busy_q; done_d = done_q; err_d = err_q; rinf_d = rinf_q;
    mul_clr_c = 1'b1; inv_start_c = 1'b0;
    mul_a_c = num_q; mul_b_c = inv_q;
    case (state_q)
      S_IDLE, S_DONE: if (Start) begin
        px_d = Px; py_d = Py; qx_d = Qx; qy_d = Qy;
        pinf_d = P_inf; qinf_d = Q_inf;
        done_d = 1'b0; err_d = 1'b0; rinf_d = 1'b0; busy_d = 1'b1;
        state_d = S_CHK;
      end
      S_CHK: begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        rx_d = '0; ry_d = '0;
        if (pinf_q && qinf_q)            rinf_d = 1'b1;
        else if (pinf_q)                 begin rx_d = qx_q; ry_d = nqy_c; end
        else if (qinf_q)                 begin rx_d = px_q; ry_d = py_q; end
        else if (px_q == qx_q && py_q == qy_q) rinf_d = 1'b1;
        else if (px_q == qx_q)           begin err_d = 1'b1; rinf_d = 1'b1; end
        else begin
          state_d = S_NUM; busy_d = 1'b1; done_d = 1'b0;
          rx_d = rx_q; ry_d = ry_q;
        end
      end
      S_NUM: begin
        num_d = sub_mod(py_q, nqy_c);
        den_d = sub_mod(px_q, qx_q);
        state_d = S_INV;
      end
      S_INV: begin
        inv_start_c = ent_q;
        if (!ent_q && inv_done) begin inv_d = inv_r; state_d = S_MUL_S; end
      end
      S_MUL_S: begin
        mul_clr_c = ent_q;
        if (!ent_q && mul_done) begin s_d = mul_p; state_d = S_MUL_S2; end
      end
      S_MUL_S2: begin
        mul_clr_c = ent_q; mul_a_c = s_q; mul_b_c = s_q;
        if (!ent_q && mul_done) begin s2_d = mul_p; state_d = S_XR; end
      end
      S_XR: begin
        rxt_d = sub_mod(sub_mod(s2_q, px_q), qx_q);
        dd_d  = sub_mod(px_q, rxt_d);
        state_d = S_MUL_Y;
      end
      S_MUL_Y: begin
        mul_clr_c = ent_q; mul_a_c = s_q; mul_b_c = dd_q;
        if (!ent_q && mul_done) begin t_d = mul_p; state_d = S_YR; end
      end
      S_YR: begin
        rx_d = rxt_q;
        ry_d = sub_mod(t_q, py_q);
        busy_d = 1'b0; done_d = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    ent_d = (state_d != state_q);
  end

  // State, operand, intermediate and output registers.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE; ent_q <= 1'b0;
      px_q <= '0; py_q <= '0; qx_q <= '0; qy_q <= '0; pinf_q <= 1'b0; qinf_q <= 1'b0;
      num_q <= '0; den_q <= '0; inv_q <= '0; s_q <= '0; s2_q <= '0;
      rxt_q <= '0; dd_q <= '0; t_q <= '0; rx_q <= '0; ry_q <= '0;
      busy_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0; rinf_q <= 1'b0;
    end else begin
      state_q <= state_d; ent_q <= ent_d;
      px_q <= px_d; py_q <= py_d; qx_q <= qx_d; qy_q <= qy_d; pinf_q <= pinf_d; qinf_q <= qinf_d;
      num_q <= num_d; den_q <= den_d; inv_q <= inv_d; s_q <= s_d; s2_q <= s2_d;
      rxt_q <= rxt_d; dd_q <= dd_d; t_q <= t_d; rx_q <= rx_d; ry_q <= ry_d;
      busy_q <= busy_d; done_q <= done_d; err_q <= err_d; rinf_q <= rinf_d;
    end
  end

  assign Busy  = busy_q;
  assign Done  = done_q;
  assign Err   = err_q;
  assign R_inf = rinf_q;
  assign Rx    = rx_q;
  assign Ry    = ry_q;
endmodule

// File: tb/tb_point_sub.sv
// Scoreboard bench for point_sub: stimulus pushes expected results, a monitor
// pops and compares on every rising Done.
module tb_point_sub;
  localparam int unsigned W = 256;
  localparam logic [W-1:0] P_MOD = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [W-1:0] GX  = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam logic [W-1:0] GY  = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
  localparam logic [W-1:0] NGY = 256'hB7C52588D95C3B9AA25B0403F1EEF75702E84BB7597AABE663B82F6F04EF2777;
  localparam logic [W-1:0] G2X = 256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5;
  localparam logic [W-1:0] G2Y = 256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A;
  localparam int MAX_CYC = 6000;

  logic         clk, Reset, Start, P_inf, Q_inf;
  logic [W-1:0] Px, Py, Qx, Qy;
  logic         Busy, Done, Err, R_inf;
  logic [W-1:0] Rx, Ry;

  typedef struct {
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    logic         rinf;
    logic         err;
    logic         chk_xy;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic done_prev = 1'b0;

  point_sub #(.W(W), .P_MOD(P_MOD)) dut (
    .clk(clk), .Reset(Reset), .Start(Start),
    .Px(Px), .Py(Py), .Qx(Qx), .Qy(Qy), .P_inf(P_inf), .Q_inf(Q_inf),
    .Busy(Busy), .Done(Done), .Err(Err), .R_inf(R_inf), .Rx(Rx), .Ry(Ry));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: compare every fresh result against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (Done && !done_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", W'(1), W'(0));
      end else begin
        e = exp_q.pop_front();
        check("r_inf", W'(R_inf), W'(e.rinf));
        check("err", W'(Err), W'(e.err));
        if (e.chk_xy) begin
          check("rx", Rx, e.rx);
          check("ry", Ry, e.ry);
        end
      end
    end
    done_prev = Done;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [W-1:0] px, input logic [W-1:0] py,
                       input logic [W-1:0] qx, input logic [W-1:0] qy,
                       input logic pinf, input logic qinf);
    Px = px; Py = py; Qx = qx; Qy = qy; P_inf = pinf; Q_inf = qinf;
  endtask

  function automatic exp_t mk(input logic [W-1:0] rx, input logic [W-1:0] ry,
                              input logic rinf, input logic err, input logic chk_xy);
    exp_t e;
    e.rx = rx; e.ry = ry; e.rinf = rinf; e.err = err; e.chk_xy = chk_xy;
    return e;
  endfunction

  // Wait (bounded) for Done; Busy must stay high until Done and be low with it.
  task automatic wait_done(input string name, output int cyc);
    logic busy_ok;
    busy_ok = 1'b1;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (Done) break;
      if (!Busy) busy_ok = 1'b0;
      if (cyc >= MAX_CYC) break;
    end
    check({name, "_done_seen"}, W'(Done), W'(1));
    check({name, "_busy_held"}, W'(busy_ok), W'(1));
    check({name, "_busy_low_at_done"}, W'(Busy), W'(0));
  endtask

  task automatic run_op(input string name, input logic [W-1:0] px, input logic [W-1:0] py,
                        input logic [W-1:0] qx, input logic [W-1:0] qy,
                        input logic pinf, input logic qinf, input exp_t e, output int cyc);
    @(negedge clk);
    exp_q.push_back(e);
    drive(px, py, qx, qy, pinf, qinf);
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    check({name, "_busy_after_start"}, W'(Busy), W'(1));
    wait_done(name, cyc);
  endtask

  initial begin
    int cyc;
    Reset = 1'b0; Start = 1'b0;
    drive('0, '0, '0, '0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_flags", W'({Busy, Done, Err, R_inf}), W'(0));
    check("reset_rx", Rx, '0);
    check("reset_ry", Ry, '0);
    Reset = 1'b1;
    @(negedge clk);

    // 2G - G = G
    run_op("sub_2g_g", G2X, G2Y, GX, GY, 1'b0, 1'b0, mk(GX, GY, 1'b0, 1'b0, 1'b1), cyc);
    // G - 2G = -G
    run_op("sub_g_2g", GX, GY, G2X, G2Y, 1'b0, 1'b0, mk(GX, NGY, 1'b0, 1'b0, 1'b1), cyc);
    // G - G = infinity, two cycles after the Start edge
    run_op("sub_g_g", GX, GY, GX, GY, 1'b0, 1'b0, mk('0, '0, 1'b1, 1'b0, 1'b0), cyc);
    check("special_latency", W'(cyc), W'(1));
    // G - (-G) is a doubling: error
    run_op("sub_g_neg_g", GX, GY, GX, NGY, 1'b0, 1'b0, mk('0, '0, 1'b1, 1'b1, 1'b1), cyc);
    // inf - G = -G
    run_op("pinf", 256'h1234, 256'h5678, GX, GY, 1'b1, 1'b0, mk(GX, NGY, 1'b0, 1'b0, 1'b1), cyc);
    // 2G - inf = 2G
    run_op("qinf", G2X, G2Y, 256'h9, 256'h3, 1'b0, 1'b1, mk(G2X, G2Y, 1'b0, 1'b0, 1'b1), cyc);
    // inf - inf = inf
    run_op("both_inf", GX, GY, G2X, G2Y, 1'b1, 1'b1, mk('0, '0, 1'b1, 1'b0, 1'b0), cyc);

    // Abort in MUL_S2: outputs clear at once, no result is reported
    @(negedge clk);
    drive(G2X, G2Y, GX, GY, 1'b0, 1'b0);
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    cyc = 0;
    while (dut.state_q !== 4'd5 && cyc < MAX_CYC) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_mul_s2", W'(dut.state_q === 4'd5), W'(1));
    Reset = 1'b0;
    #1;
    check("abort_flags", W'({Busy, Done, Err, R_inf}), W'(0));
    check("abort_rx", Rx, '0);
    check("abort_ry", Ry, '0);
    @(negedge clk);
    Reset = 1'b1;
    run_op("rerun_2g_g", G2X, G2Y, GX, GY, 1'b0, 1'b0, mk(GX, GY, 1'b0, 1'b0, 1'b1), cyc);

    // Back-to-back with Start held high
    @(negedge clk);
    exp_q.push_back(mk(GX, GY, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(mk(GX, NGY, 1'b0, 1'b0, 1'b1));
    drive(G2X, G2Y, GX, GY, 1'b0, 1'b0);
    Start = 1'b1;
    wait_done("b2b_first", cyc);
    drive(GX, GY, G2X, G2Y, 1'b0, 1'b0);
    @(negedge clk);
    check("b2b_done_drop", W'(Done), W'(0));
    wait_done("b2b_second", cyc);
    Start = 1'b0;

    repeat (4) @(negedge clk);
    check("scoreboard_empty", W'(exp_q.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
